// File: rtl/booth_multiplier_param_if.sv
// Handshake bundle between the controller FSM (master) and the Booth multiplier (slave).
interface booth_multiplier_param_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic                 sign_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 valid;
    logic [2*WIDTH-1:0]   p;

    modport master (output start, sign_mode, a, b, input busy, valid, p);
    modport slave  (input start, sign_mode, a, b, output busy, valid, p);
endinterface

// File: rtl/booth_multiplier_param.sv
// Multi-cycle Booth multiplier, signed or unsigned per operation, held result.
// Define BOOTH_RADIX4_EN to build the modified (radix-4) Booth datapath instead of radix-2.
module booth_multiplier_param #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    booth_multiplier_param_if.slave  bus
);

`ifdef BOOTH_RADIX4_EN
    localparam int EXT   = WIDTH + 2;
    localparam int UW    = WIDTH + 4;
    localparam int STEPS = (WIDTH + 2) / 2;
    localparam int SHIFT = 2;

    if (WIDTH % 2 != 0) begin : g_width_odd
        $error("booth_multiplier_param: WIDTH must be even in the radix-4 build");
    end
`else
    localparam int EXT   = WIDTH + 1;
    localparam int UW    = WIDTH + 2;
    localparam int STEPS = WIDTH + 1;
    localparam int SHIFT = 1;
`endif
    // Accumulator = {upper partial product, extended multiplier, Booth guard bit}.
    localparam int AW = UW + EXT + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [EXT-1:0]        a_ext;
    logic signed [AW-1:0]  acc;
    logic [2*WIDTH-1:0]    p_q;
    logic                  valid_q;

    logic [EXT-1:0]        a_in;
    logic [EXT-1:0]        b_in;
    logic signed [UW-1:0]  a_up;
    logic signed [UW-1:0]  addend;
    logic [UW-1:0]         upper_sum;
    logic signed [AW-1:0]  acc_next;

    assign a_in = {{(EXT-WIDTH){bus.sign_mode & bus.a[WIDTH-1]}}, bus.a};
    assign b_in = {{(EXT-WIDTH){bus.sign_mode & bus.b[WIDTH-1]}}, bus.b};
    assign a_up = {{(UW-EXT){a_ext[EXT-1]}}, a_ext};

    always_comb begin
        // NOTE: addend gets a default before the decode so no latch can be inferred.
        addend = '0;
`ifdef BOOTH_RADIX4_EN
        case (acc[2:0])
            3'b001, 3'b010: addend = a_up;
            3'b011:         addend = a_up <<< 1;
            3'b100:         addend = -(a_up <<< 1);
            3'b101, 3'b110: addend = -a_up;
            default:        addend = '0;
        endcase
`else
        case (acc[1:0])
            2'b01:   addend = a_up;
            2'b10:   addend = -a_up;
            default: addend = '0;
        endcase
`endif
        upper_sum = acc[AW-1 -: UW] + addend;
        acc_next  = $signed({upper_sum, acc[AW-UW-1:0]}) >>> SHIFT;
    end

    // NOTE: every register here uses non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_ext   <= '0;
            acc     <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_ext <= a_in;
                        acc   <= {{UW{1'b0}}, b_in, 1'b0};
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(STEPS - 1)) state <= DONE;
                end
                DONE: begin
                    p_q     <= acc[2*WIDTH:1];
                    valid_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.valid = valid_q;
    assign bus.p     = p_q;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Self-checking bench: WIDTH=4, 8 and 16 instances against an arithmetic reference model.
module tb_booth_multiplier_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_multiplier_param_if #(.WIDTH(4))  if4 ();
    booth_multiplier_param_if #(.WIDTH(8))  if8 ();
    booth_multiplier_param_if #(.WIDTH(16)) if16 ();

    booth_multiplier_param #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    booth_multiplier_param #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
    booth_multiplier_param #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

    int n_checks = 0;
    int n_fail   = 0;

    // Cycles from accept edge to the cycle in which valid is high.
    function automatic int exp_lat(int w);
`ifdef BOOTH_RADIX4_EN
        return (w + 2) / 2 + 1;
`else
        return w + 2;
`endif
    endfunction

    // Exact product of two w-bit operands, truncated to 2w bits.
    function automatic longint ref_mul(int w, bit sm, longint a, longint b);
        longint m  = (longint'(1) << w) - 1;
        longint av = a & m;
        longint bv = b & m;
        if (sm && av[w-1]) av = av - (longint'(1) << w);
        if (sm && bv[w-1]) bv = bv - (longint'(1) << w);
        return (av * bv) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Issues one operation to all three instances and records product and latency of each.
    task automatic do_op(input bit sm,
                         input logic [3:0] a4, input logic [3:0] b4,
                         input logic [7:0] a8, input logic [7:0] b8,
                         input logic [15:0] a16, input logic [15:0] b16,
                         output logic [7:0] p4, output logic [15:0] p8, output logic [31:0] p16,
                         output int l4, output int l8, output int l16);
        l4 = 0; l8 = 0; l16 = 0;
        p4 = 'x; p8 = 'x; p16 = 'x;
        if4.sign_mode = sm;  if4.a = a4;   if4.b = b4;   if4.start = 1'b1;
        if8.sign_mode = sm;  if8.a = a8;   if8.b = b8;   if8.start = 1'b1;
        if16.sign_mode = sm; if16.a = a16; if16.b = b16; if16.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0; if8.start = 1'b0; if16.start = 1'b0;
        for (int k = 1; k <= 40 && (l4 == 0 || l8 == 0 || l16 == 0); k++) begin
            @(negedge clk);
            if (if4.valid && l4 == 0)   begin l4 = k;  p4 = if4.p;   end
            if (if8.valid && l8 == 0)   begin l8 = k;  p8 = if8.p;   end
            if (if16.valid && l16 == 0) begin l16 = k; p16 = if16.p; end
        end
    endtask

    task automatic test_reset();
        logic [7:0] p4; logic [15:0] p8; logic [31:0] p16;
        int l4, l8, l16, pulses;
        n_checks++;
        if ({if4.busy, if4.valid, if8.busy, if8.valid, if16.busy, if16.valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {if4.busy, if4.valid, if8.busy, if8.valid, if16.busy, if16.valid});
        end
        n_checks++;
        if ({if4.p, if8.p, if16.p} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_p: got %h expected 0", {if4.p, if8.p, if16.p});
        end
        rst = 1'b0;
        @(negedge clk);
        do_op(1'b1, 4'd0, 4'd0, 8'd5, 8'd3, 16'd0, 16'd0, p4, p8, p16, l4, l8, l16);
        n_checks++;
        if (p8 !== 16'd15) begin
            n_fail++; $display("FAIL pre_reset_5x3: got %h expected 000f", p8);
        end
        // Abort 7*9 in the middle of CALC.
        if8.sign_mode = 1'b1; if8.a = 8'd7; if8.b = 8'd9; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({if8.busy, if8.valid} !== 2'b00 || if8.p !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_abort: got busy=%b valid=%b p=%h expected 0 0 0000",
                     if8.busy, if8.valid, if8.p);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (if8.valid || if8.busy) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL reset_no_valid: got %0d active cycles expected 0", pulses);
        end
        do_op(1'b1, 4'd0, 4'd0, 8'd7, 8'd9, 16'd0, 16'd0, p4, p8, p16, l4, l8, l16);
        n_checks++;
        if (p8 !== 16'd63) begin
            n_fail++; $display("FAIL after_reset_7x9: got %h expected 003f", p8);
        end
        n_checks++;
        if (l8 !== exp_lat(8)) begin
            n_fail++; $display("FAIL after_reset_latency: got %0d expected %0d", l8, exp_lat(8));
        end
    endtask

    task automatic test_signed_corners();
        logic [3:0]  ta[4] = '{4'h8, 4'h8, 4'h0, 4'hF};
        logic [3:0]  tb[4] = '{4'h8, 4'h7, 4'hB, 4'hF};
        logic [7:0]  te[4] = '{8'h40, 8'hC8, 8'h00, 8'h01};
        logic [7:0]  p4; logic [15:0] p8; logic [31:0] p16;
        int l4, l8, l16;
        for (int i = 0; i < 4; i++) begin
            // Most-negative operand on the wider instances alongside the first row.
            if (i == 0)
                do_op(1'b1, ta[i], tb[i], 8'h80, 8'h80, 16'h8000, 16'h8000, p4, p8, p16, l4, l8, l16);
            else
                do_op(1'b1, ta[i], tb[i], 8'h7F, 8'h80, 16'h7FFF, 16'h8000, p4, p8, p16, l4, l8, l16);
            n_checks++;
            if (p4 !== te[i]) begin
                n_fail++; $display("FAIL signed_w4_%0d: got %h expected %h", i, p4, te[i]);
            end
            n_checks++;
            if (p8 !== (i == 0 ? 16'h4000 : 16'hC080)) begin
                n_fail++; $display("FAIL signed_w8_%0d: got %h", i, p8);
            end
            n_checks++;
            if (p16 !== (i == 0 ? 32'h4000_0000 : 32'hC000_8000)) begin
                n_fail++; $display("FAIL signed_w16_%0d: got %h", i, p16);
            end
            n_checks++;
            if (l4 !== exp_lat(4) || l16 !== exp_lat(16)) begin
                n_fail++;
                $display("FAIL signed_latency_%0d: got %0d/%0d expected %0d/%0d",
                         i, l4, l16, exp_lat(4), exp_lat(16));
            end
        end
    endtask

    task automatic test_unsigned();
        bit          ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0]  ta[4] = '{8'd255, 8'd128, 8'd255, 8'd128};
        logic [7:0]  tb[4] = '{8'd255, 8'd2, 8'd255, 8'd2};
        logic [15:0] te[4] = '{16'hFE01, 16'h0100, 16'h0001, 16'hFF00};
        logic [7:0]  p4; logic [15:0] p8; logic [31:0] p16;
        int l4, l8, l16;
        for (int i = 0; i < 4; i++) begin
            do_op(ts[i], 4'd0, 4'd0, ta[i], tb[i], 16'd0, 16'd0, p4, p8, p16, l4, l8, l16);
            n_checks++;
            if (p8 !== te[i]) begin
                n_fail++;
                $display("FAIL mode%0d_%0dx%0d: got %h expected %h", ts[i], ta[i], tb[i], p8, te[i]);
            end
        end
    endtask

    task automatic test_handshake();
        logic [7:0] p4; logic [15:0] p8; logic [31:0] p16;
        int l4, l8, l16, bad;
        int lat = exp_lat(8);
        do_op(1'b0, 4'd0, 4'd0, 8'd3, 8'd4, 16'd0, 16'd0, p4, p8, p16, l4, l8, l16);
        n_checks++;
        if (p8 !== 16'd12) begin
            n_fail++; $display("FAIL hs_setup: got %h expected 000c", p8);
        end
        if8.sign_mode = 1'b0; if8.a = 8'd12; if8.b = 8'd11; if8.start = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (k < lat) begin
                if ({if8.busy, if8.valid} !== 2'b10 || if8.p !== 16'd12) begin
                    n_fail++;
                    $display("FAIL hs_busy_cycle%0d: got busy=%b valid=%b p=%h expected 1 0 000c",
                             k, if8.busy, if8.valid, if8.p);
                end
            end else if ({if8.busy, if8.valid} !== 2'b01 || if8.p !== 16'd132) begin
                n_fail++;
                $display("FAIL hs_result: got busy=%b valid=%b p=%h expected 0 1 0084",
                         if8.busy, if8.valid, if8.p);
            end
            if (k < lat) begin
                if8.start = 1'b1;
                if8.a = 8'($urandom);
                if8.b = 8'($urandom);
                if8.sign_mode = 1'($urandom);
            end else begin
                if8.start = 1'b0;
            end
        end
        bad = 0;
        repeat (lat + 2) begin
            @(negedge clk);
            if (if8.valid || if8.busy || if8.p !== 16'd132) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL hs_single_accept: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        bit          bs[3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0]  ba[3] = '{8'hFD, 8'd200, 8'h64};
        logic [7:0]  bb[3] = '{8'd7, 8'd3, 8'h9C};
        logic [15:0] be[3] = '{16'hFFEB, 16'h0258, 16'hD8F0};
        logic [15:0] held = 16'd132;
        int lat = exp_lat(8);
        int idx = 0;
        int last_t = 0;
        int exp_t;
        if8.sign_mode = bs[0]; if8.a = ba[0]; if8.b = bb[0]; if8.start = 1'b1;
        for (int t = 1; t <= 4 * (lat + 1) + 4 && idx < 3; t++) begin
            @(negedge clk);
            n_checks++;
            if (if8.valid) begin
                exp_t = (idx == 0) ? lat + 1 : last_t + lat + 1;
                if (if8.p !== be[idx] || t !== exp_t) begin
                    n_fail++;
                    $display("FAIL b2b_op%0d: got p=%h at t=%0d expected p=%h at t=%0d",
                             idx, if8.p, t, be[idx], exp_t);
                end
                held = be[idx];
                last_t = t;
                idx++;
                if (idx < 3) begin
                    if8.sign_mode = bs[idx]; if8.a = ba[idx]; if8.b = bb[idx];
                end else begin
                    if8.start = 1'b0;
                end
            end else if (if8.p !== held) begin
                n_fail++; $display("FAIL b2b_hold_t%0d: got %h expected %h", t, if8.p, held);
            end
        end
        n_checks++;
        if (idx !== 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d results expected 3", idx);
        end
        if8.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random(input bit sm, input int n_ops);
        logic [3:0]  a4, b4; logic [7:0] a8, b8; logic [15:0] a16, b16;
        logic [7:0]  p4; logic [15:0] p8; logic [31:0] p16;
        longint e4, e8, e16;
        int l4, l8, l16;
        for (int i = 0; i < n_ops; i++) begin
            a4 = 4'($urandom);   b4 = 4'($urandom);
            a8 = 8'($urandom);   b8 = 8'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            do_op(sm, a4, b4, a8, b8, a16, b16, p4, p8, p16, l4, l8, l16);
            e4  = ref_mul(4, sm, longint'(a4), longint'(b4));
            e8  = ref_mul(8, sm, longint'(a8), longint'(b8));
            e16 = ref_mul(16, sm, longint'(a16), longint'(b16));
            n_checks += 6;
            if (p4 !== e4[7:0]) begin
                n_fail++; $display("FAIL rand_w4 m%0d %h*%h: got %h expected %h", sm, a4, b4, p4, e4[7:0]);
            end
            if (p8 !== e8[15:0]) begin
                n_fail++; $display("FAIL rand_w8 m%0d %h*%h: got %h expected %h", sm, a8, b8, p8, e8[15:0]);
            end
            if (p16 !== e16[31:0]) begin
                n_fail++; $display("FAIL rand_w16 m%0d %h*%h: got %h expected %h", sm, a16, b16, p16, e16[31:0]);
            end
            if (l4 !== exp_lat(4)) begin
                n_fail++; $display("FAIL rand_lat_w4: got %0d expected %0d", l4, exp_lat(4));
            end
            if (l8 !== exp_lat(8)) begin
                n_fail++; $display("FAIL rand_lat_w8: got %0d expected %0d", l8, exp_lat(8));
            end
            if (l16 !== exp_lat(16)) begin
                n_fail++; $display("FAIL rand_lat_w16: got %0d expected %0d", l16, exp_lat(16));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if4.start = 1'b0;  if4.sign_mode = 1'b0;  if4.a = '0;  if4.b = '0;
        if8.start = 1'b0;  if8.sign_mode = 1'b0;  if8.a = '0;  if8.b = '0;
        if16.start = 1'b0; if16.sign_mode = 1'b0; if16.a = '0; if16.b = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_signed_corners();
        test_unsigned();
        test_handshake();
        test_back_to_back();
        test_random(1'b1, 500);
        test_random(1'b0, 500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
